// File: rtl/biquad_coeff_pkg.sv
// Shared definitions for the biquad coefficient loader: coefficient width, FSM
// encoding and the cascade shift-order convention.
package biquad_coeff_pkg;

    localparam int unsigned COEFF_BITS = 32'd18;

    typedef logic [COEFF_BITS-1:0] coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // Index 0 is the first DSP of the cascade; the B1 chain is a shift register,
    // so the farthest DSP's word must be shifted in first.
    function automatic int unsigned first_shift_idx(input int unsigned n);
        return n - 32'd1;
    endfunction

endpackage

// File: rtl/biquad_coeff_loader_if.sv
// Host-side register/control bus of the biquad coefficient loader.
interface biquad_coeff_loader_if
    import biquad_coeff_pkg::*;
#(
    parameter int unsigned NCOEFF = 32'd4
);
    localparam int unsigned AW = addr_width(NCOEFF);

    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    coeff_t        wr_dat_i;
    logic          wr_ready_o;
    logic          commit_i;
    logic          busy_o;
    logic          done_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_dat_i, commit_i,
        input  wr_ready_o, busy_o, done_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_dat_i, commit_i,
        output wr_ready_o, busy_o, done_o
    );

endinterface

// File: rtl/biquad_coeff_shadow.sv
// Host-writable shadow register file, NCOEFF x COEFF_BITS, with every entry
// readable asynchronously.
module biquad_coeff_shadow
    import biquad_coeff_pkg::*;
#(
    parameter  int unsigned NCOEFF = 32'd4,
    localparam int unsigned AW     = addr_width(NCOEFF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  coeff_t        wdat,
    output coeff_t        words [NCOEFF]
);

    coeff_t mem_r [NCOEFF];

    // Shadow storage; cleared on reset, written one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NCOEFF); i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdat;
        end
    end

    assign words = mem_r;

endmodule

// File: rtl/biquad_coeff_loader.sv
// Coefficient loader for a biquad pole IIR: shadow register file plus the FSM that
// shifts it into the DSP B1 cascade and pulses the B2 update.
// Optional readback of the committed coefficients: BIQUAD_COEFF_READBACK_EN.
module biquad_coeff_loader
    import biquad_coeff_pkg::*;
#(
    parameter int unsigned NCOEFF = 32'd4
) (
    input  logic                          clk,
    input  logic                          rst,
    biquad_coeff_loader_if.slave          host,
    output coeff_t                        coeff_dat_o,
    output logic                          coeff_wr_o,
    output logic                          coeff_update_o
`ifdef BIQUAD_COEFF_READBACK_EN
    ,
    input  logic [addr_width(NCOEFF)-1:0] rd_addr_i,
    output coeff_t                        rd_dat_o
`endif
);

    localparam int unsigned   AW       = addr_width(NCOEFF);
    localparam logic [AW-1:0] LAST_IDX = AW'(first_shift_idx(NCOEFF));
    localparam logic [AW-1:0] ONE      = AW'(32'd1);

    state_e        state_r;
    logic [AW-1:0] idx_r;
    coeff_t        coeff_dat_r;
    logic          coeff_wr_r;
    logic          coeff_update_r;
    logic          done_r;
    logic          busy_r;
    logic          wr_ready_r;
    logic          shadow_we_s;
    coeff_t        first_word_s;
    coeff_t        words_s [NCOEFF];

    // Shadow writes land only while idle and in range; a same-cycle write to the
    // first-shifted entry is forwarded so the commit carries the new value.
    always_comb begin
        shadow_we_s  = 1'b0;
        first_word_s = words_s[LAST_IDX];
        if ((state_r == ST_IDLE) && host.wr_en_i && (32'(host.wr_addr_i) < NCOEFF)) begin
            shadow_we_s = 1'b1;
        end else begin
            shadow_we_s = 1'b0;
        end
        if (shadow_we_s && (host.wr_addr_i == LAST_IDX)) begin
            first_word_s = host.wr_dat_i;
        end else begin
            first_word_s = words_s[LAST_IDX];
        end
    end

    biquad_coeff_shadow #(
        .NCOEFF (NCOEFF)
    ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .we    (shadow_we_s),
        .waddr (host.wr_addr_i),
        .wdat  (host.wr_dat_i),
        .words (words_s)
    );

    // Load sequencer: IDLE -> SHIFT (NCOEFF words, farthest first) -> UPDATE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            idx_r          <= '0;
            coeff_dat_r    <= '0;
            coeff_wr_r     <= 1'b0;
            coeff_update_r <= 1'b0;
            done_r         <= 1'b0;
            busy_r         <= 1'b0;
            wr_ready_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    coeff_update_r <= 1'b0;
                    done_r         <= 1'b0;
                    if (host.commit_i) begin
                        state_r     <= ST_SHIFT;
                        idx_r       <= LAST_IDX;
                        coeff_dat_r <= first_word_s;
                        coeff_wr_r  <= 1'b1;
                        busy_r      <= 1'b1;
                        wr_ready_r  <= 1'b0;
                    end else begin
                        coeff_dat_r <= '0;
                        coeff_wr_r  <= 1'b0;
                        busy_r      <= 1'b0;
                        wr_ready_r  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (idx_r == '0) begin
                        state_r        <= ST_UPDATE;
                        coeff_dat_r    <= '0;
                        coeff_wr_r     <= 1'b0;
                        coeff_update_r <= 1'b1;
                        done_r         <= 1'b1;
                    end else begin
                        idx_r       <= idx_r - ONE;
                        coeff_dat_r <= words_s[idx_r - ONE];
                        coeff_wr_r  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state_r        <= ST_IDLE;
                    coeff_update_r <= 1'b0;
                    done_r         <= 1'b0;
                    busy_r         <= 1'b0;
                    wr_ready_r     <= 1'b1;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    idx_r          <= '0;
                    coeff_dat_r    <= '0;
                    coeff_wr_r     <= 1'b0;
                    coeff_update_r <= 1'b0;
                    done_r         <= 1'b0;
                    busy_r         <= 1'b0;
                    wr_ready_r     <= 1'b1;
                end
            endcase
        end
    end

    assign coeff_dat_o     = coeff_dat_r;
    assign coeff_wr_o      = coeff_wr_r;
    assign coeff_update_o  = coeff_update_r;
    assign host.done_o     = done_r;
    assign host.busy_o     = busy_r;
    assign host.wr_ready_o = wr_ready_r;

`ifdef BIQUAD_COEFF_READBACK_EN
    coeff_t snap_r [NCOEFF];
    coeff_t rd_dat_r;

    // Snapshot taken on the edge entering UPDATE, so it mirrors what B2 now holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NCOEFF); i++) begin
                snap_r[i] <= '0;
            end
            rd_dat_r <= '0;
        end else begin
            if ((state_r == ST_SHIFT) && (idx_r == '0)) begin
                snap_r <= words_s;
            end
            if (32'(rd_addr_i) < NCOEFF) begin
                rd_dat_r <= snap_r[rd_addr_i];
            end else begin
                rd_dat_r <= '0;
            end
        end
    end

    assign rd_dat_o = rd_dat_r;
`endif

endmodule
